// File: rtl/sram_ana_master.sv
// Digital initiator for the analog-encoded SRAM port: turns single-word requests into
// rail-level clk/we/addr/din sequences and decodes the returned dout levels.
module sram_ana_master #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned ANA_WIDTH  = 8,
  parameter int unsigned FULL_SCALE = 255,
  parameter int unsigned THRESHOLD  = 128,
  parameter int unsigned GUARD      = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 req_valid,
  output logic                                 req_ready,
  input  logic                                 req_we,
  input  logic [ADDR_WIDTH-1:0]                req_addr,
  input  logic [DATA_WIDTH-1:0]                req_wdata,
  output logic                                 rsp_valid,
  output logic [DATA_WIDTH-1:0]                rsp_rdata,
  output logic                                 rsp_marginal,
  output logic [ANA_WIDTH-1:0]                 clk_a,
  output logic [ANA_WIDTH-1:0]                 we_a,
  output logic [ADDR_WIDTH-1:0][ANA_WIDTH-1:0] addr_a,
  output logic [DATA_WIDTH-1:0][ANA_WIDTH-1:0] din_a,
  input  logic [DATA_WIDTH-1:0][ANA_WIDTH-1:0] dout_a
);

  localparam logic [ANA_WIDTH-1:0] LVL_HI  = ANA_WIDTH'(FULL_SCALE);
  localparam logic [ANA_WIDTH-1:0] LVL_LO  = '0;
  localparam logic [ANA_WIDTH-1:0] LVL_THR = ANA_WIDTH'(THRESHOLD);
  localparam logic [ANA_WIDTH-1:0] MARG_LO = ANA_WIDTH'(GUARD);
  localparam logic [ANA_WIDTH-1:0] MARG_HI = ANA_WIDTH'(FULL_SCALE - GUARD);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_RISE,
    ST_HOLD,
    ST_SAMPLE
  } state_e;

  state_e                                state_q, state_d;
  logic                                  ready_q, ready_d;
  logic                                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]                 rdata_q, rdata_d;
  logic                                  marg_q, marg_d;
  logic [ANA_WIDTH-1:0]                  clk_a_q, clk_a_d;
  logic [ANA_WIDTH-1:0]                  we_a_q, we_a_d;
  logic [ADDR_WIDTH-1:0][ANA_WIDTH-1:0]  addr_a_q, addr_a_d;
  logic [DATA_WIDTH-1:0][ANA_WIDTH-1:0]  din_a_q, din_a_d;

  // State and output registers; reset also aborts any in-flight access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      marg_q      <= 1'b0;
      clk_a_q     <= LVL_LO;
      we_a_q      <= LVL_LO;
      addr_a_q    <= '0;
      din_a_q     <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      marg_q      <= marg_d;
      clk_a_q     <= clk_a_d;
      we_a_q      <= we_a_d;
      addr_a_q    <= addr_a_d;
      din_a_q     <= din_a_d;
    end
  end

  // Access sequencer: setup, clk_a high for two cycles, fall, then sample dout_a.
  always_comb begin
    state_d     = state_q;
    ready_d     = ready_q;
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;
    marg_d      = marg_q;
    clk_a_d     = clk_a_q;
    we_a_d      = we_a_q;
    addr_a_d    = addr_a_q;
    din_a_d     = din_a_q;

    case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        if (req_valid && ready_q) begin
          state_d = ST_SETUP;
          ready_d = 1'b0;
          we_a_d  = req_we ? LVL_HI : LVL_LO;
          for (int i = 0; i < int'(ADDR_WIDTH); i++) begin
            addr_a_d[i] = req_addr[i] ? LVL_HI : LVL_LO;
          end
          // Reads park din_a at zero so the macro never sees stale write data.
          for (int i = 0; i < int'(DATA_WIDTH); i++) begin
            din_a_d[i] = (req_we && req_wdata[i]) ? LVL_HI : LVL_LO;
          end
        end
      end
      ST_SETUP: begin
        clk_a_d = LVL_HI;
        state_d = ST_RISE;
      end
      ST_RISE: begin
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        clk_a_d = LVL_LO;
        we_a_d  = LVL_LO;
        state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        marg_d = 1'b0;
        for (int i = 0; i < int'(DATA_WIDTH); i++) begin
          rdata_d[i] = (dout_a[i] >= LVL_THR);
          if ((dout_a[i] > MARG_LO) && (dout_a[i] < MARG_HI)) begin
            marg_d = 1'b1;
          end
        end
        rsp_valid_d = 1'b1;
        ready_d     = 1'b1;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign req_ready    = ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rdata_q;
  assign rsp_marginal = marg_q;
  assign clk_a        = clk_a_q;
  assign we_a         = we_a_q;
  assign addr_a       = addr_a_q;
  assign din_a        = din_a_q;

endmodule
